diff_freq_serial_out: RTL and testbench
=======================================

DIFF_FREQ_SERIAL_OUT -- requirements
Module: diff_freq_serial_out

Interface
REQ-001 The block SHALL have these parameters:
- DATA_BIT, default 32: pattern width.
- PACK_NUM, default 9: bytes per command packet.
- LOW_PERIOD_CLK, default 8'd20: clocks per bit when the frequency bit is 0.
- HIGH_PERIOD_CLK, default 8'd5: clocks per bit when the frequency bit is 1.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: single system clock.
- rst_n, in, 1: asynchronous active-low reset.
- i_data, in, 8: received UART byte.
- i_rx_done_tick, in, 1: one-cycle strobe; i_data is valid this cycle.
- o_serial_out, out, 16: one serial line per channel.
- o_bit_tick, out, 1: one-cycle pulse at the end of any channel's bit period.
- o_done_tick, out, 1: one-cycle pulse when any channel completes a one-shot transfer.

REQ-003 The block SHALL use one clock; reset SHALL be asynchronous and active-low (clk, rst_n).

Function
REQ-004 Each i_rx_done_tick SHALL store i_data into the packet buffer at the current byte index (0..PACK_NUM-1); the index SHALL then increment.

REQ-005 Packet byte layout, little-endian:
- Bytes 0-3: out_pattern[31:0], byte 0 = bits [7:0].
- Bytes 4-7: freq_pattern[31:0], byte 4 = bits [7:0].
- Byte 8: control byte.

REQ-006 Control byte fields:
- [7:4] channel, 0-15.
- [3] idle level.
- [2] mode: 0 = one-shot, 1 = repeat.
- [1:0] cmd: 00 = no-op, 01 = start, 10 = stop, 11 = ignored.

REQ-007 Packet completion:
- On the 8th-index byte, the index SHALL wrap to 0.
- A one-cycle dispatch SHALL be issued on the following cycle to the addressed channel only.

REQ-008 There is no inter-byte timeout; the packet index SHALL reset only on rst_n or after a completed packet.

REQ-009 Start command: the channel SHALL load out_pattern, freq_pattern, mode and idle level, and drive out_pattern[0] on the cycle after dispatch. Total latency from the 9th i_rx_done_tick to bit 0 on the line is 2 cycles.

REQ-010 Bit order SHALL be LSB first. Bit k SHALL be held for HIGH_PERIOD_CLK cycles if freq_pattern[k]=1, else LOW_PERIOD_CLK cycles.

REQ-011 Bit timing:
- Each channel SHALL have a per-bit counter running 0..period-1.
- On the last cycle of each period, o_bit_tick SHALL be asserted and the bit index SHALL advance.

REQ-012 One-shot mode:
- After bit 31's final cycle, o_done_tick SHALL pulse in that same cycle.
- The line SHALL return to the idle level on the next cycle and the channel SHALL go IDLE.

REQ-013 Repeat mode: after bit 31, the channel SHALL wrap to bit 0 with no gap, with no o_done_tick, indefinitely.

REQ-014 Stop command: the channel SHALL go IDLE and drive its idle level on the cycle after dispatch, without an o_done_tick.

REQ-015 A start to a busy channel SHALL abort the current transfer and restart at bit 0 with the new data. Stop or no-op to an idle channel SHALL have no effect, except that a no-op SHALL update the stored idle level.

REQ-016 Per-channel state machine:
- IDLE -> RUN on start.
- RUN -> IDLE on stop or on one-shot completion.
- RUN -> RUN on repeat wrap or restart.

REQ-017 o_bit_tick and o_done_tick SHALL be the OR of all 16 channels' ticks. Simultaneous events across channels SHALL produce a single-cycle pulse.

REQ-018 Channels SHALL operate independently and concurrently; loading one channel SHALL not disturb the timing of the others.

REQ-019 A period parameter of 0 SHALL be treated as 1.

Reset
REQ-020 While rst_n=0:
- o_serial_out = 16'h0000, o_bit_tick = 0, o_done_tick = 0.
- Packet index = 0, buffers cleared.
- All channels IDLE with idle level 0, counters 0.

REQ-021 Reset asserted mid-transfer SHALL abort immediately; on release, all lines SHALL be low and idle.

Structure
REQ-022 A shared package SHALL hold the cmd encodings (NOP/START/STOP), the mode encodings (ONE_SHOT=0, REPEAT=1), the control-byte field positions, and the state enum {IDLE, RUN}.

REQ-023 One sub-module, serial_out_channel, SHALL implement a single channel (REQ-009 to REQ-016) and be instantiated 16 times via generate. The top SHALL contain the packet assembler and dispatch decode.

Verification
REQ-024 Reset check: rst_n low -> o_serial_out=0000 and no ticks.

REQ-025 One-shot, channel 0: bytes 55 00 55 00 00 00 00 00, control 0x01 -> out[0] carries 0x00550055 LSB-first at 20 clk/bit (640 clocks); one o_done_tick; the line is low afterwards.

REQ-026 Repeat, channel 1: same data, control 0x15 -> the pattern repeats every 640 clocks with no o_done_tick; then control 0x12 (stop) -> the line goes low on the cycle after dispatch.

REQ-027 Mixed frequency: freq bytes FF 00 00 00 -> bits 0-7 last 5 clocks each and bits 8-31 last 20 clocks each (520 clocks total); o_bit_tick count = 32.

REQ-028 Concurrency: start channel 2 (one-shot), then channel 5 (repeat) mid-transfer -> channel 2 timing is unchanged; both lines are correct.

REQ-029 Idle high: control 0x39 (channel 3, idle 1, one-shot) -> the line returns to 1 after done; reset mid-transfer -> the line is 0.

Source files
------------

// File: rtl/diff_freq_serial_out_pkg.sv
// rtl/diff_freq_serial_out_pkg.sv - shared encodings for diff_freq_serial_out
//
// Command and mode encodings, control-byte field positions, packet byte
// offsets and the per-channel state enum used by the top and the channels.
package diff_freq_serial_out_pkg;

    localparam int NUM_CHANNELS = 16;

    // Control byte cmd field
    localparam logic [1:0] CMD_NOP   = 2'b00;
    localparam logic [1:0] CMD_START = 2'b01;
    localparam logic [1:0] CMD_STOP  = 2'b10;

    // Control byte mode bit
    localparam logic MODE_ONE_SHOT = 1'b0;
    localparam logic MODE_REPEAT   = 1'b1;

    // Control byte field positions
    localparam int CTRL_CH_LSB   = 4;
    localparam int CTRL_CH_W     = 4;
    localparam int CTRL_IDLE_BIT = 3;
    localparam int CTRL_MODE_BIT = 2;
    localparam int CTRL_CMD_LSB  = 0;
    localparam int CTRL_CMD_W    = 2;

    // Packet byte offsets (little-endian patterns)
    localparam int PKT_OUT_BYTE  = 0;
    localparam int PKT_FREQ_BYTE = 4;
    localparam int PKT_CTRL_BYTE = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } chan_state_e;

    // A zero period would never reach its terminal count; run it as 1.
    function automatic logic [7:0] clamp_period(input logic [7:0] p);
        return (p == 8'd0) ? 8'd1 : p;
    endfunction

endpackage

// File: rtl/diff_freq_serial_out_channel.sv
// rtl/diff_freq_serial_out_channel.sv - one serial output channel
//
// Purpose: shifts a DATA_BIT pattern out LSB first, each bit held for a
// short or long period chosen by the matching frequency-pattern bit.
// Supports one-shot and repeat modes, stop, restart and idle level.
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   i_dispatch        - one-cycle command strobe addressed to this channel
//   i_cmd             - NOP / START / STOP (3 is ignored)
//   i_mode, i_idle    - repeat flag and idle line level
//   i_out_pattern     - bits to drive
//   i_freq_pattern    - per-bit period select (1 = high frequency)
//   o_serial          - registered serial line
//   o_bit_tick        - high on the last cycle of every bit period
//   o_done_tick       - high on the last cycle of a one-shot transfer
module serial_out_channel
    import diff_freq_serial_out_pkg::*;
#(
    parameter int         DATA_BIT        = 32,
    parameter logic [7:0] LOW_PERIOD_CLK  = 8'd20,
    parameter logic [7:0] HIGH_PERIOD_CLK = 8'd5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_dispatch,
    input  logic [1:0]          i_cmd,
    input  logic                i_mode,
    input  logic                i_idle,
    input  logic [DATA_BIT-1:0] i_out_pattern,
    input  logic [DATA_BIT-1:0] i_freq_pattern,
    output logic                o_serial,
    output logic                o_bit_tick,
    output logic                o_done_tick
);

    localparam int             IDX_W    = (DATA_BIT > 1) ? $clog2(DATA_BIT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BIT - 1);
    localparam logic [7:0]     LOW_P    = clamp_period(LOW_PERIOD_CLK);
    localparam logic [7:0]     HIGH_P   = clamp_period(HIGH_PERIOD_CLK);

    chan_state_e          state_q, state_d;
    logic [DATA_BIT-1:0]  out_q, out_d;
    logic [DATA_BIT-1:0]  freq_q, freq_d;
    logic                 mode_q, mode_d;
    logic                 idle_q, idle_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [7:0]           cnt_q, cnt_d;
    logic                 serial_q, serial_d;
    logic                 bit_tick_q, bit_tick_d;
    logic                 done_tick_q, done_tick_d;

    logic [7:0]           last_cnt_q;
    logic [7:0]           last_cnt_d;

    always_comb begin
        last_cnt_q = (freq_q[idx_q] ? HIGH_P : LOW_P) - 8'd1;

        state_d = state_q;
        out_d   = out_q;
        freq_d  = freq_q;
        mode_d  = mode_q;
        idle_d  = idle_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;

        // Free-running bit timing; a command this cycle overrides it below.
        if (state_q == ST_RUN) begin
            if (cnt_q == last_cnt_q) begin
                cnt_d = 8'd0;
                if (idx_q == LAST_IDX) begin
                    idx_d = '0;
                    if (mode_q == MODE_ONE_SHOT) begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end

        if (i_dispatch) begin
            case (i_cmd)
                CMD_START: begin
                    state_d = ST_RUN;
                    out_d   = i_out_pattern;
                    freq_d  = i_freq_pattern;
                    mode_d  = i_mode;
                    idle_d  = i_idle;
                    idx_d   = '0;
                    cnt_d   = 8'd0;
                end
                CMD_STOP: begin
                    if (state_q == ST_RUN) begin
                        state_d = ST_IDLE;
                        idx_d   = '0;
                        cnt_d   = 8'd0;
                    end
                end
                CMD_NOP: begin
                    idle_d = i_idle;
                end
                default: ;
            endcase
        end

        // Outputs are registered: evaluate them against the next state so
        // they line up with the counter value they describe.
        last_cnt_d  = (freq_d[idx_d] ? HIGH_P : LOW_P) - 8'd1;
        bit_tick_d  = (state_d == ST_RUN) && (cnt_d == last_cnt_d);
        done_tick_d = bit_tick_d && (idx_d == LAST_IDX) && (mode_d == MODE_ONE_SHOT);
        serial_d    = (state_d == ST_RUN) ? out_d[idx_d] : idle_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            out_q       <= '0;
            freq_q      <= '0;
            mode_q      <= MODE_ONE_SHOT;
            idle_q      <= 1'b0;
            idx_q       <= '0;
            cnt_q       <= 8'd0;
            serial_q    <= 1'b0;
            bit_tick_q  <= 1'b0;
            done_tick_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            freq_q      <= freq_d;
            mode_q      <= mode_d;
            idle_q      <= idle_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            serial_q    <= serial_d;
            bit_tick_q  <= bit_tick_d;
            done_tick_q <= done_tick_d;
        end
    end

    assign o_serial    = serial_q;
    assign o_bit_tick  = bit_tick_q;
    assign o_done_tick = done_tick_q;

endmodule

// File: rtl/diff_freq_serial_out.sv
// rtl/diff_freq_serial_out.sv - 16-channel dual-frequency serial pattern generator
//
// Purpose: assembles PACK_NUM-byte command packets from a UART byte stream
// and dispatches each completed packet to the addressed channel.
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset
//   i_data          - received byte, valid with i_rx_done_tick
//   i_rx_done_tick  - one-cycle byte strobe
//   o_serial_out    - one serial line per channel
//   o_bit_tick      - OR of all channel bit ticks
//   o_done_tick     - OR of all channel one-shot done ticks
module diff_freq_serial_out
    import diff_freq_serial_out_pkg::*;
#(
    parameter int         DATA_BIT        = 32,
    parameter int         PACK_NUM        = 9,
    parameter logic [7:0] LOW_PERIOD_CLK  = 8'd20,
    parameter logic [7:0] HIGH_PERIOD_CLK = 8'd5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              i_data,
    input  logic                    i_rx_done_tick,
    output logic [NUM_CHANNELS-1:0] o_serial_out,
    output logic                    o_bit_tick,
    output logic                    o_done_tick
);

    localparam int               IDX_W    = (PACK_NUM > 1) ? $clog2(PACK_NUM) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PACK_NUM - 1);

    logic [PACK_NUM*8-1:0] pkt_q, pkt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  dispatch_q, dispatch_d;

    // Packet assembler: no inter-byte timeout, index only wraps on the last byte.
    always_comb begin
        pkt_d      = pkt_q;
        idx_d      = idx_q;
        dispatch_d = 1'b0;
        if (i_rx_done_tick) begin
            pkt_d[8*int'(idx_q) +: 8] = i_data;
            if (idx_q == LAST_IDX) begin
                idx_d      = '0;
                dispatch_d = 1'b1;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_q      <= '0;
            idx_q      <= '0;
            dispatch_q <= 1'b0;
        end else begin
            pkt_q      <= pkt_d;
            idx_q      <= idx_d;
            dispatch_q <= dispatch_d;
        end
    end

    // Packet fields, valid while dispatch_q is high.
    logic [7:0]            ctrl;
    logic [DATA_BIT-1:0]   out_pattern;
    logic [DATA_BIT-1:0]   freq_pattern;
    logic [CTRL_CH_W-1:0]  ctrl_ch;
    logic [CTRL_CMD_W-1:0] ctrl_cmd;

    assign ctrl         = pkt_q[8*PKT_CTRL_BYTE +: 8];
    assign out_pattern  = pkt_q[8*PKT_OUT_BYTE +: DATA_BIT];
    assign freq_pattern = pkt_q[8*PKT_FREQ_BYTE +: DATA_BIT];
    assign ctrl_ch      = ctrl[CTRL_CH_LSB +: CTRL_CH_W];
    assign ctrl_cmd     = ctrl[CTRL_CMD_LSB +: CTRL_CMD_W];

    logic [NUM_CHANNELS-1:0] ch_bit_tick;
    logic [NUM_CHANNELS-1:0] ch_done_tick;

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
        logic ch_dispatch;
        assign ch_dispatch = dispatch_q && (ctrl_ch == CTRL_CH_W'(i));

        serial_out_channel #(
            .DATA_BIT        (DATA_BIT),
            .LOW_PERIOD_CLK  (LOW_PERIOD_CLK),
            .HIGH_PERIOD_CLK (HIGH_PERIOD_CLK)
        ) u_ch (
            .clk            (clk),
            .rst_n          (rst_n),
            .i_dispatch     (ch_dispatch),
            .i_cmd          (ctrl_cmd),
            .i_mode         (ctrl[CTRL_MODE_BIT]),
            .i_idle         (ctrl[CTRL_IDLE_BIT]),
            .i_out_pattern  (out_pattern),
            .i_freq_pattern (freq_pattern),
            .o_serial       (o_serial_out[i]),
            .o_bit_tick     (ch_bit_tick[i]),
            .o_done_tick    (ch_done_tick[i])
        );
    end

    // Channel ticks are registered, so the OR is a clean single-cycle pulse.
    assign o_bit_tick  = |ch_bit_tick;
    assign o_done_tick = |ch_done_tick;

endmodule

// File: tb/tb_diff_freq_serial_out.sv
// tb/tb_diff_freq_serial_out.sv - scoreboard testbench for diff_freq_serial_out
module tb_diff_freq_serial_out;

    localparam int MAXC = 30000;
    localparam int LOW  = 20;
    localparam int HIGH = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [7:0]  i_data = 8'h00;
    logic        i_rx_done_tick = 1'b0;
    logic [15:0] o_serial_out;
    logic        o_bit_tick;
    logic        o_done_tick;

    diff_freq_serial_out #(
        .DATA_BIT        (32),
        .PACK_NUM        (9),
        .LOW_PERIOD_CLK  (8'd20),
        .HIGH_PERIOD_CLK (8'd5)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_data         (i_data),
        .i_rx_done_tick (i_rx_done_tick),
        .o_serial_out   (o_serial_out),
        .o_bit_tick     (o_bit_tick),
        .o_done_tick    (o_done_tick)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected response timeline, written when stimulus is issued.
    logic [15:0] exp_line [MAXC];
    logic [15:0] exp_tick [MAXC];
    logic [15:0] exp_done [MAXC];
    int          m_end  [16];
    logic        m_idle [16];

    int n_checks = 0;
    int n_fail = 0;
    int n_bit_ticks = 0;
    int n_done_ticks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic fill_idle(input int c, input int from, input logic lvl);
        for (int t = from; t < MAXC; t++) exp_line[t][c] = lvl;
    endtask

    task automatic clear_ticks(input int c, input int from);
        for (int t = from; t < MAXC; t++) begin
            exp_tick[t][c] = 1'b0;
            exp_done[t][c] = 1'b0;
        end
    endtask

    task automatic model_reset(input int from);
        for (int t = from; t < MAXC; t++) begin
            exp_line[t] = 16'h0;
            exp_tick[t] = 16'h0;
            exp_done[t] = 16'h0;
        end
        for (int c = 0; c < 16; c++) begin
            m_idle[c] = 1'b0;
            m_end[c]  = 0;
        end
    endtask

    // Reference model: a packet whose last byte is sampled at edge e takes
    // effect on the line from cycle e+1 onward.
    task automatic model_apply(input int e, input logic [31:0] outp, input logic [31:0] freqp,
                               input logic [7:0] ctrl);
        int c;
        int s;
        int t;
        int p;
        logic idle;
        logic rep;
        logic [1:0] cmd;
        c    = int'(ctrl[7:4]);
        idle = ctrl[3];
        rep  = ctrl[2];
        cmd  = ctrl[1:0];
        s    = e + 1;
        case (cmd)
            2'b01: begin
                m_idle[c] = idle;
                clear_ticks(c, s);
                t = s;
                do begin
                    for (int k = 0; k < 32; k++) begin
                        p = freqp[k] ? HIGH : LOW;
                        for (int j = 0; j < p; j++) begin
                            if (t < MAXC) begin
                                exp_line[t][c] = outp[k];
                                exp_tick[t][c] = (j == p - 1);
                                exp_done[t][c] = !rep && (k == 31) && (j == p - 1);
                            end
                            t++;
                        end
                    end
                end while (rep && t < MAXC);
                if (rep) m_end[c] = MAXC;
                else begin
                    m_end[c] = t;
                    fill_idle(c, t, idle);
                end
            end
            2'b10: begin
                if (s < m_end[c]) begin
                    clear_ticks(c, s);
                    fill_idle(c, s, m_idle[c]);
                    m_end[c] = s;
                end
            end
            2'b00: begin
                m_idle[c] = idle;
                fill_idle(c, (s > m_end[c]) ? s : m_end[c], idle);
            end
            default: ;
        endcase
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, output int e);
        @(posedge clk);
        #1;
        i_data = b;
        i_rx_done_tick = 1'b1;
        e = cyc + 1;
        @(posedge clk);
        #1;
        i_rx_done_tick = 1'b0;
        i_data = 8'($urandom);
        repeat (gap) @(posedge clk);
    endtask

    task automatic send_packet(input logic [31:0] outp, input logic [31:0] freqp,
                               input logic [7:0] ctrl, input int maxgap);
        logic [71:0] pkt;
        int e;
        pkt = {ctrl, freqp, outp};
        for (int i = 0; i < 9; i++)
            send_byte(pkt[8*i +: 8], (i == 8) ? 0 : int'($urandom_range(0, maxgap)), e);
        model_apply(e, outp, freqp, ctrl);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
    endtask

    // Monitor: compares every sampled cycle against the scoreboard timeline.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("reset_outputs", {14'd0, o_done_tick, o_bit_tick, o_serial_out}, 32'd0);
        end else if (cyc < MAXC) begin
            check("line_and_ticks", {14'd0, o_done_tick, o_bit_tick, o_serial_out},
                  {14'd0, |exp_done[cyc], |exp_tick[cyc], exp_line[cyc]});
            if (o_bit_tick) n_bit_ticks++;
            if (o_done_tick) n_done_ticks++;
        end
    end

    initial begin
        #(MAXC * 10);
        $display("FAIL watchdog: cycle budget exhausted at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        logic [7:0] ctrl;
        int r;
        model_reset(0);
        #1 rst_n = 1'b0;
        wait_cycles(5);
        #1 rst_n = 1'b1;
        wait_cycles(3);

        // One-shot, channel 0, all low-frequency bits.
        b = n_done_ticks;
        send_packet(32'h0055_0055, 32'h0, 8'h01, 2);
        wait_cycles(700);
        check("oneshot_done_count", n_done_ticks - b, 1);

        // Repeat on channel 1, then stop.
        b = n_done_ticks;
        send_packet(32'h0055_0055, 32'h0, 8'h15, 0);
        wait_cycles(1400);
        send_packet(32'h0, 32'h0, 8'h12, 1);
        wait_cycles(40);
        check("repeat_no_done", n_done_ticks - b, 0);

        // Mixed frequency on channel 4.
        b = n_bit_ticks;
        send_packet(32'h0055_0055, 32'h0000_00FF, 8'h41, 0);
        wait_cycles(560);
        check("mixed_bit_ticks", n_bit_ticks - b, 32);

        // Concurrency: channel 2 one-shot, channel 5 repeat started mid-transfer.
        send_packet($urandom, $urandom, 8'h21, 1);
        wait_cycles(150);
        send_packet($urandom, $urandom, 8'h55, 3);
        wait_cycles(700);
        send_packet($urandom, $urandom, 8'h52, 0);

        // Restart of a busy channel.
        send_packet($urandom, $urandom, 8'h61, 0);
        wait_cycles(100);
        send_packet($urandom, $urandom, 8'h6D, 0);
        wait_cycles(200);
        send_packet($urandom, $urandom, 8'h61, 2);
        wait_cycles(90);
        send_packet($urandom, $urandom, 8'h62, 0);

        // Idle-channel commands: no-op sets idle, stop and cmd 3 do nothing.
        send_packet($urandom, $urandom, 8'h78, 0);
        wait_cycles(5);
        send_packet($urandom, $urandom, 8'h72, 0);
        send_packet($urandom, $urandom, 8'h7B, 0);
        wait_cycles(10);
        send_packet($urandom, $urandom, 8'h70, 0);

        // Idle high on channel 3, then reset mid-transfer with a partial packet pending.
        send_packet($urandom, $urandom, 8'h39, 1);
        wait_cycles(700);
        send_packet($urandom, $urandom, 8'h39, 0);
        wait_cycles(100);
        send_byte(8'hA5, 0, r);
        send_byte(8'h5A, 0, r);
        send_byte(8'h3C, 0, r);
        @(posedge clk);
        #1 rst_n = 1'b0;
        model_reset(cyc);
        wait_cycles(3);
        #1 rst_n = 1'b1;
        wait_cycles(4);

        // Randomized packets across all channels.
        for (int n = 0; n < 14; n++) begin
            r = int'($urandom_range(0, 9));
            ctrl[7:4] = 4'($urandom);
            ctrl[3]   = 1'($urandom);
            ctrl[2]   = 1'($urandom);
            ctrl[1:0] = (r < 5) ? 2'b01 : (r < 7) ? 2'b10 : (r < 9) ? 2'b00 : 2'b11;
            send_packet($urandom, $urandom, ctrl, 3);
            wait_cycles(int'($urandom_range(0, 400)));
        end
        wait_cycles(700);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
